// File: rtl/multiexp_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multiexp_feeder_pkg
//  Description : Shared types for the multi-exponentiation feeder: field
//                element, Jacobian point, and the packed {point, scalar}
//                batch entry stored by the feeder and unpacked by the core.
//                Also holds the feeder state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package multiexp_feeder_pkg;

    localparam int c_FE_BITS = 256;

    typedef logic [c_FE_BITS-1:0] fe_t;

    typedef struct packed {
        fe_t x;
        fe_t y;
        fe_t z;
    } jb_point_t;

    typedef struct packed {
        jb_point_t pnt;
        fe_t       scl;
    } multiexp_ent_t;

    localparam int MULTIEXP_ENT_BITS = $bits(fe_t) + $bits(jb_point_t);

    // Feeder state encoding
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOAD   = 2'd1;
    localparam logic [1:0] c_ST_REPLAY = 2'd2;

endpackage
`default_nettype wire

// File: rtl/multiexp_feeder_ram.sv
`default_nettype none
// ============================================================================
//  Module      : multiexp_feeder_ram
//  Description : Simple dual-port RAM, one write port and one read port with
//                a registered, enable-gated read (1-cycle latency). Contents
//                are never reset so block/ultra RAM can be inferred.
//  Ports       : i_clk                         - clock
//                i_wr_en / i_wr_addr / i_wr_dat - write port
//                i_rd_en / i_rd_addr           - read request
//                o_rd_dat                      - read data, held while !i_rd_en
//  Revision    : 1.0 - initial release
// ============================================================================
module multiexp_feeder_ram #(
    parameter int DEPTH     = 1024,
    parameter int WIDTH     = 1024,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_wr_en,
    input  logic [ADDR_BITS-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]     i_wr_dat,
    input  logic                 i_rd_en,
    input  logic [ADDR_BITS-1:0] i_rd_addr,
    output logic [WIDTH-1:0]     o_rd_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
        // Read register only advances when enabled, so the last read word
        // stays on o_rd_dat and doubles as the feeder's output register.
        if (i_rd_en) begin
            o_rd_dat <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/multiexp_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : multiexp_feeder
//  Description : Loads one batch of {point, scalar} entries into local RAM,
//                then replays the whole batch PASSES times in index order to
//                multiexp_core (one replay per scalar bit).
//  Ports       : i_clk, i_rst          - clock, synchronous active-high reset
//                i_num_in              - batch size, sampled on first beat
//                i_pnt_scl_*           - load stream in, o_pnt_scl_i_rdy ready
//                o_pnt_scl_*           - replay stream out, i_pnt_scl_o_rdy ready
//                o_busy                - high while loading or replaying
//                o_pass                - current replay pass index
//                o_err                 - sticky bad batch size flag
//  Revision    : 1.0 - initial release
// ============================================================================
module multiexp_feeder
    import multiexp_feeder_pkg::*;
#(
    parameter int DAT_BITS  = c_FE_BITS,
    parameter int ENT_BITS  = MULTIEXP_ENT_BITS,
    parameter int CTL_BITS  = 8,
    parameter int MAX_IN    = 1024,
    parameter int PASSES    = DAT_BITS,
    parameter int DAT_BYTS  = (ENT_BITS + 7) / 8,
    parameter int MOD_BITS  = $clog2(DAT_BYTS),
    parameter int PASS_BITS = $clog2(PASSES + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [63:0]           i_num_in,
    // load stream
    input  logic                  i_pnt_scl_val,
    input  logic [DAT_BYTS*8-1:0] i_pnt_scl_dat,
    input  logic                  i_pnt_scl_sop,
    input  logic                  i_pnt_scl_eop,
    input  logic                  i_pnt_scl_err,
    input  logic [CTL_BITS-1:0]   i_pnt_scl_ctl,
    input  logic [MOD_BITS-1:0]   i_pnt_scl_mod,
    output logic                  o_pnt_scl_i_rdy,
    // replay stream
    output logic                  o_pnt_scl_val,
    output logic [DAT_BYTS*8-1:0] o_pnt_scl_dat,
    output logic                  o_pnt_scl_sop,
    output logic                  o_pnt_scl_eop,
    output logic                  o_pnt_scl_err,
    output logic [CTL_BITS-1:0]   o_pnt_scl_ctl,
    output logic [MOD_BITS-1:0]   o_pnt_scl_mod,
    input  logic                  i_pnt_scl_o_rdy,
    // status
    output logic                  o_busy,
    output logic [PASS_BITS-1:0]  o_pass,
    output logic                  o_err
);

    localparam int c_EW = $clog2(MAX_IN);
    localparam int c_DW = DAT_BYTS * 8;

    // control
    logic [1:0]           r_state;
    logic                 r_in_rdy;
    logic [c_EW-1:0]      r_last_e;      // n-1
    logic [c_EW-1:0]      r_wr_addr;
    logic [c_EW-1:0]      r_e;           // next entry to read
    logic [PASS_BITS-1:0] r_p;           // pass of next entry to read
    logic                 r_issue_done;
    logic [PASS_BITS-1:0] r_pass;
    logic                 r_err;

    // output stage: RAM read register (m) plus one skid entry (s)
    logic                 r_m_val;
    logic [CTL_BITS-1:0]  r_m_ctl;
    logic                 r_m_last;
    logic                 r_s_val;
    logic [ENT_BITS-1:0]  r_s_dat;
    logic [CTL_BITS-1:0]  r_s_ctl;
    logic                 r_s_last;

    logic                 w_in_fire;
    logic                 w_size_ok;
    logic [c_EW-1:0]      w_num_m1;
    logic                 w_wr_en;
    logic [c_EW-1:0]      w_wr_addr;
    logic                 w_issue;
    logic                 w_issue_last;
    logic                 w_o_val;
    logic                 w_o_last;
    logic                 w_done;
    logic [ENT_BITS-1:0]  w_ram_dat;
    logic [ENT_BITS-1:0]  w_ent;
    logic [CTL_BITS-1:0]  w_o_ctl;
    logic                 w_unused;

    // Framing and ctl of the load stream carry no meaning here.
    assign w_unused = ^{i_pnt_scl_sop, i_pnt_scl_eop, i_pnt_scl_err,
                        i_pnt_scl_ctl, i_pnt_scl_mod};

    assign w_in_fire = i_pnt_scl_val & r_in_rdy;
    assign w_size_ok = (i_num_in != 64'd0) && (i_num_in <= 64'(MAX_IN));
    // n <= MAX_IN, so n-1 always fits in c_EW bits even when n == 2**c_EW.
    assign w_num_m1  = i_num_in[c_EW-1:0] - c_EW'(1);
    assign w_wr_en   = w_in_fire & (((r_state == c_ST_IDLE) & w_size_ok) |
                                    (r_state == c_ST_LOAD));
    assign w_wr_addr = (r_state == c_ST_LOAD) ? r_wr_addr : '0;

    // A read is only issued while the skid slot is free: if the current RAM
    // word is stalled downstream it moves into the skid as the new read lands.
    assign w_issue      = (r_state == c_ST_REPLAY) & ~r_issue_done & ~r_s_val;
    assign w_issue_last = (r_e == r_last_e) & (r_p == PASS_BITS'(PASSES - 1));

    assign w_o_val  = r_s_val | r_m_val;
    assign w_o_last = r_s_val ? r_s_last : r_m_last;
    assign w_done   = w_o_val & i_pnt_scl_o_rdy & w_o_last;
    assign w_ent    = r_s_val ? r_s_dat : w_ram_dat;
    assign w_o_ctl  = r_s_val ? r_s_ctl : (r_m_val ? r_m_ctl : '0);

    multiexp_feeder_ram #(
        .DEPTH     (MAX_IN),
        .WIDTH     (ENT_BITS),
        .ADDR_BITS (c_EW)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_dat  (i_pnt_scl_dat[ENT_BITS-1:0]),
        .i_rd_en   (w_issue),
        .i_rd_addr (r_e),
        .o_rd_dat  (w_ram_dat)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= c_ST_IDLE;
            r_in_rdy     <= 1'b0;
            r_last_e     <= '0;
            r_wr_addr    <= '0;
            r_e          <= '0;
            r_p          <= '0;
            r_issue_done <= 1'b0;
            r_pass       <= '0;
            r_err        <= 1'b0;
            r_m_val      <= 1'b0;
            r_m_ctl      <= '0;
            r_m_last     <= 1'b0;
            r_s_val      <= 1'b0;
            r_s_ctl      <= '0;
            r_s_last     <= 1'b0;
        end else begin
            // ---------------- state machine ----------------
            case (r_state)
                c_ST_IDLE: begin
                    r_in_rdy <= 1'b1;
                    if (w_in_fire) begin
                        if (w_size_ok) begin
                            r_last_e     <= w_num_m1;
                            r_wr_addr    <= c_EW'(1);
                            r_e          <= '0;
                            r_p          <= '0;
                            r_issue_done <= 1'b0;
                            r_pass       <= '0;
                            if (w_num_m1 == '0) begin
                                r_state  <= c_ST_REPLAY;
                                r_in_rdy <= 1'b0;
                            end else begin
                                r_state  <= c_ST_LOAD;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_ST_LOAD: begin
                    if (w_in_fire) begin
                        r_wr_addr <= r_wr_addr + c_EW'(1);
                        if (r_wr_addr == r_last_e) begin
                            r_state  <= c_ST_REPLAY;
                            r_in_rdy <= 1'b0;
                        end
                    end
                end
                c_ST_REPLAY: begin
                    if (w_done) begin
                        r_state  <= c_ST_IDLE;
                        r_in_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= c_ST_IDLE;
                    r_in_rdy <= 1'b0;
                end
            endcase

            // ---------------- read issue counters ----------------
            if (w_issue) begin
                if (r_e == '0) begin
                    r_pass <= r_p;
                end
                if (r_e == r_last_e) begin
                    r_e <= '0;
                    if (r_p == PASS_BITS'(PASSES - 1)) begin
                        r_issue_done <= 1'b1;
                    end else begin
                        r_p <= r_p + PASS_BITS'(1);
                    end
                end else begin
                    r_e <= r_e + c_EW'(1);
                end
            end

            // ---------------- output register + skid ----------------
            if (r_s_val) begin
                // skid holds the older beat; the RAM register is frozen
                if (i_pnt_scl_o_rdy) begin
                    r_s_val <= 1'b0;
                end
            end else if (w_issue) begin
                if (r_m_val & ~i_pnt_scl_o_rdy) begin
                    r_s_val  <= 1'b1;
                    r_s_dat  <= w_ram_dat;
                    r_s_ctl  <= r_m_ctl;
                    r_s_last <= r_m_last;
                end
                r_m_val  <= 1'b1;
                r_m_ctl  <= CTL_BITS'(r_e);
                r_m_last <= w_issue_last;
            end else if (i_pnt_scl_o_rdy) begin
                r_m_val <= 1'b0;
            end

            if (w_done) begin
                r_m_val <= 1'b0;
                r_s_val <= 1'b0;
            end
        end
    end

    assign o_pnt_scl_i_rdy = r_in_rdy;
    assign o_pnt_scl_val   = w_o_val;
    assign o_pnt_scl_dat   = w_o_val ? c_DW'(w_ent) : '0;
    assign o_pnt_scl_sop   = w_o_val;
    assign o_pnt_scl_eop   = w_o_val;
    assign o_pnt_scl_err   = 1'b0;
    assign o_pnt_scl_ctl   = w_o_ctl;
    assign o_pnt_scl_mod   = '0;
    assign o_busy          = (r_state != c_ST_IDLE);
    assign o_pass          = r_pass;
    assign o_err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_multiexp_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiexp_feeder
//  Description : Self-checking bench for multiexp_feeder. Random batches are
//                loaded and every replayed beat is compared with the expected
//                sequence entry[k % n], ctl = k % n, total n * PASSES beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiexp_feeder;
    import multiexp_feeder_pkg::*;

    localparam int MAX_IN    = 1024;
    localparam int PASSES    = 256;
    localparam int CTL_BITS  = 8;
    localparam int ENT_BITS  = MULTIEXP_ENT_BITS;
    localparam int DAT_BYTS  = (ENT_BITS + 7) / 8;
    localparam int DW        = DAT_BYTS * 8;
    localparam int MOD_BITS  = $clog2(DAT_BYTS);
    localparam int PASS_BITS = $clog2(PASSES + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [63:0]          num_in;
    logic                 ld_val;
    logic [DW-1:0]        ld_dat;
    logic                 ld_sop, ld_eop, ld_err;
    logic [CTL_BITS-1:0]  ld_ctl;
    logic [MOD_BITS-1:0]  ld_mod;
    logic                 ld_rdy;
    logic                 rp_val;
    logic [DW-1:0]        rp_dat;
    logic                 rp_sop, rp_eop, rp_err;
    logic [CTL_BITS-1:0]  rp_ctl;
    logic [MOD_BITS-1:0]  rp_mod;
    logic                 rp_rdy;
    logic                 busy;
    logic [PASS_BITS-1:0] pass_idx;
    logic                 err_flag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_hs  = 0;

    logic [DW-1:0] ents [MAX_IN];
    logic [DW-1:0] nxt  [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multiexp_feeder #(
        .CTL_BITS (CTL_BITS),
        .MAX_IN   (MAX_IN),
        .PASSES   (PASSES)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_num_in        (num_in),
        .i_pnt_scl_val   (ld_val),
        .i_pnt_scl_dat   (ld_dat),
        .i_pnt_scl_sop   (ld_sop),
        .i_pnt_scl_eop   (ld_eop),
        .i_pnt_scl_err   (ld_err),
        .i_pnt_scl_ctl   (ld_ctl),
        .i_pnt_scl_mod   (ld_mod),
        .o_pnt_scl_i_rdy (ld_rdy),
        .o_pnt_scl_val   (rp_val),
        .o_pnt_scl_dat   (rp_dat),
        .o_pnt_scl_sop   (rp_sop),
        .o_pnt_scl_eop   (rp_eop),
        .o_pnt_scl_err   (rp_err),
        .o_pnt_scl_ctl   (rp_ctl),
        .o_pnt_scl_mod   (rp_mod),
        .i_pnt_scl_o_rdy (rp_rdy),
        .o_busy          (busy),
        .o_pass          (pass_idx),
        .o_err           (err_flag)
    );

    task automatic chk_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic rand_ent(output logic [DW-1:0] v);
        for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
    endtask

    task automatic make_batch(input int n);
        for (int j = 0; j < n; j++) rand_ent(ents[j]);
    endtask

    function automatic int find_ent(input int n, input logic [DW-1:0] d);
        for (int j = 0; j < n; j++) if (ents[j] == d) return j;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ld_val = 1'b0; rp_rdy = 1'b0;
        @(negedge clk);
        #1;
        chk_val("rst_val",  rp_val,   0);
        chk_val("rst_busy", busy,     0);
        chk_val("rst_pass", pass_idx, 0);
        chk_val("rst_err",  err_flag, 0);
        chk_val("rst_ldrdy", ld_rdy,  0);
        chk_val("rst_dat",  (rp_dat == '0 && rp_ctl == '0) ? 1 : 0, 1);
        rst = 1'b0;
    endtask

    // Drive n beats of ents[] into the load port; num_in only matters on
    // the first beat, so later beats carry random junk there.
    task automatic load(input int n, input longint num, input bit gaps);
        int i = 0;
        int t = 0;
        bit vld;
        while (i < n && t < n * 8 + 50) begin
            @(negedge clk);
            vld    = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            ld_val = vld;
            ld_dat = ents[i];
            num_in = (i == 0) ? 64'(num) : {$urandom, $urandom};
            ld_sop = 1'($urandom_range(0, 1));
            ld_eop = 1'($urandom_range(0, 1));
            ld_ctl = 8'($urandom);
            #1;
            if (vld && ld_rdy) begin
                if (i == n - 1) last_hs = cyc;
                i++;
            end
            t++;
        end
        if (i < n) chk_val("load_timeout", i, n);
    endtask

    // Collect replay beats; stop_beats > 0 ends early (for mid-run reset).
    // hold_next keeps the first beat of the next batch pending on the load
    // port, which must stay unaccepted for the whole replay.
    task automatic replay(input int n, input bit rnd, input int stop_beats, input bit hold_next);
        int total, k, t, lim, idx, maxp, stall_bad;
        bit pv, seen;
        logic [DW-1:0] pd;
        total = (stop_beats > 0) ? stop_beats : n * PASSES;
        lim = n * PASSES * 4 + 100;
        k = 0; t = 0; maxp = 0; stall_bad = 0; pv = 0; seen = 0; pd = '0;
        while (k < total && t < lim) begin
            @(negedge clk);
            ld_val = hold_next;
            if (hold_next) begin
                ld_dat = nxt[0];
                num_in = 64'd5;
            end
            rp_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (hold_next && ld_rdy) stall_bad++;
            if (pv) chk_val("hold", (rp_val && rp_dat == pd) ? 1 : 0, 1);
            if (rp_val) begin
                if (!seen) begin
                    seen = 1;
                    chk_val("first_lat",  cyc - last_hs, 2);
                    chk_val("first_pass", pass_idx, 0);
                    chk_val("busy_on",    busy, 1);
                end
                idx = find_ent(n, rp_dat);
                chk_val("ent", idx, k % n);
                chk_val("ctl", rp_ctl, (k % n) % 256);
                chk_val("flags", longint'({rp_sop, rp_eop, rp_err, (rp_mod != '0)}), 12);
                if (int'(pass_idx) > maxp) maxp = int'(pass_idx);
                if (rp_rdy) k++;
            end
            pv = rp_val && !rp_rdy;
            pd = rp_dat;
            t++;
        end
        if (k < total) chk_val("replay_timeout", k, total);
        if (hold_next) chk_val("stall", stall_bad, 0);
        if (stop_beats == 0) begin
            chk_val("max_pass", maxp, PASSES - 1);
            @(negedge clk);
            ld_val = 1'b0; rp_rdy = 1'b1;
            #1;
            chk_val("busy_fall", busy, 0);
            chk_val("no_extra",  rp_val, 0);
            chk_val("idle_rdy",  ld_rdy, 1);
        end
    endtask

    task automatic bad_size(input longint num);
        load(1, num, 1'b0);
        repeat (4) begin
            @(negedge clk);
            ld_val = 1'b0;
            #1;
            chk_val("bad_val",  rp_val, 0);
            chk_val("bad_busy", busy,   0);
        end
        chk_val("bad_err",   err_flag, 1);
        chk_val("bad_ldrdy", ld_rdy,   1);
    endtask

    initial begin
        rst = 1'b0; num_in = '0; ld_val = 1'b0; ld_dat = '0;
        ld_sop = 1'b0; ld_eop = 1'b0; ld_err = 1'b0; ld_ctl = '0; ld_mod = '0;
        rp_rdy = 1'b0;

        do_reset();

        // 4 entries, always ready, then same batch with random ready
        make_batch(4);
        load(4, 4, 1'b0);
        replay(4, 1'b0, 0, 1'b0);
        load(4, 4, 1'b1);
        replay(4, 1'b1, 0, 1'b0);

        // single entry
        make_batch(1);
        load(1, 1, 1'b0);
        replay(1, 1'b1, 0, 1'b0);

        // bad sizes, then a good batch still works
        bad_size(0);
        bad_size(MAX_IN + 1);
        make_batch(2);
        load(2, 2, 1'b1);
        replay(2, 1'b0, 0, 1'b0);
        chk_val("err_sticky", err_flag, 1);

        // reset during pass 3, then a fresh batch
        make_batch(4);
        load(4, 4, 1'b0);
        replay(4, 1'b1, 3 * 4 + 2, 1'b0);
        do_reset();
        make_batch(4);
        load(4, 4, 1'b0);
        replay(4, 1'b0, 0, 1'b0);

        // back-to-back batches: second load waits for the first replay
        make_batch(3);
        for (int j = 0; j < 5; j++) rand_ent(nxt[j]);
        load(3, 3, 1'b0);
        replay(3, 1'b1, 0, 1'b1);
        for (int j = 0; j < 5; j++) ents[j] = nxt[j];
        load(5, 5, 1'b0);
        replay(5, 1'b1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
